// File: rtl/input_conditioner_pkg.sv
// Shared constants for the user-input conditioning front end.
package input_conditioner_pkg;
   localparam int CLK_HZ                  = 100000000;
   localparam int DEFAULT_DEBOUNCE_CYCLES = 1000000;
   localparam int DEFAULT_SYNC_STAGES     = 2;
   localparam int SIM_DEBOUNCE_CYCLES     = 4;
   localparam int NUM_CH                  = 4;
endpackage

// File: rtl/debounce_channel.sv
// One input channel: metastability synchroniser, stable-count debouncer,
// and registered edge pulses aligned with the debounced level change.
module debounce_channel
   import input_conditioner_pkg::*;
#(
   parameter int SYNC_STAGES     = DEFAULT_SYNC_STAGES,
   parameter int DEBOUNCE_CYCLES = DEFAULT_DEBOUNCE_CYCLES,
   parameter int CNT_W           = 20
) (
   input  logic CLK,
   input  logic RST_N,
   input  logic raw,
   output logic db,
   output logic rise,
   output logic fall
);
   localparam logic [CNT_W-1:0] LAST = CNT_W'(DEBOUNCE_CYCLES - 1);

   logic [SYNC_STAGES-1:0] sync;
   logic                   s;
   logic [CNT_W-1:0]       cnt;

   assign s = sync[SYNC_STAGES-1];

   always_ff @(posedge CLK or negedge RST_N) begin
      if (!RST_N) sync <= '0;
      else        sync <= {sync[SYNC_STAGES-2:0], raw};
   end

   // Any cycle where s agrees with db restarts the count, so only an
   // unbroken run of DEBOUNCE_CYCLES disagreeing samples flips db.
   always_ff @(posedge CLK or negedge RST_N) begin
      if (!RST_N) begin
         cnt  <= '0;
         db   <= 1'b0;
         rise <= 1'b0;
         fall <= 1'b0;
      end else begin
         rise <= 1'b0;
         fall <= 1'b0;
         if (s == db) begin
            cnt <= '0;
         end else if (cnt == LAST) begin
            cnt  <= '0;
            db   <= s;
            rise <= s;
            fall <= ~s;
         end else begin
            cnt <= cnt + 1'b1;
         end
      end
   end
endmodule

// File: rtl/input_conditioner.sv
// Synchronises and debounces BTNC and SW0..SW2; BTNC also gets press/release pulses.
module input_conditioner
   import input_conditioner_pkg::*;
#(
   parameter int SYNC_STAGES     = DEFAULT_SYNC_STAGES,
   parameter int DEBOUNCE_CYCLES = DEFAULT_DEBOUNCE_CYCLES,
   parameter int CNT_W           = 20
) (
   input  logic CLK,
   input  logic RST_N,
   input  logic BTNC,
   input  logic SW0,
   input  logic SW1,
   input  logic SW2,
   output logic BTNC_DB,
   output logic SW0_DB,
   output logic SW1_DB,
   output logic SW2_DB,
   output logic BTNC_RISE,
   output logic BTNC_FALL
);
   logic [NUM_CH-1:0] raw;
   logic [NUM_CH-1:0] db;

   assign raw = {SW2, SW1, SW0, BTNC};
   assign {SW2_DB, SW1_DB, SW0_DB, BTNC_DB} = db;

   // Channel 0 is the push-button; only it needs edge pulses.
   for (genvar i = 0; i < NUM_CH; i++) begin : g_ch
      if (i == 0) begin : g_btn
         debounce_channel #(
            .SYNC_STAGES(SYNC_STAGES), .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES), .CNT_W(CNT_W)
         ) u_ch (
            .CLK(CLK), .RST_N(RST_N), .raw(raw[i]), .db(db[i]),
            .rise(BTNC_RISE), .fall(BTNC_FALL)
         );
      end else begin : g_sw
         debounce_channel #(
            .SYNC_STAGES(SYNC_STAGES), .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES), .CNT_W(CNT_W)
         ) u_ch (
            .CLK(CLK), .RST_N(RST_N), .raw(raw[i]), .db(db[i]),
            .rise(), .fall()
         );
      end
   end
endmodule

// File: tb/tb_input_conditioner.sv
// Table-driven bench for input_conditioner at SYNC_STAGES=2, DEBOUNCE_CYCLES=4.
module tb_input_conditioner;
   import input_conditioner_pkg::*;

   logic CLK = 1'b0;
   logic RST_N = 1'b0;
   logic BTNC = 1'b0, SW0 = 1'b0, SW1 = 1'b0, SW2 = 1'b0;
   logic BTNC_DB, SW0_DB, SW1_DB, SW2_DB, BTNC_RISE, BTNC_FALL;

   input_conditioner #(
      .SYNC_STAGES(2), .DEBOUNCE_CYCLES(SIM_DEBOUNCE_CYCLES), .CNT_W(3)
   ) dut (
      .CLK(CLK), .RST_N(RST_N), .BTNC(BTNC), .SW0(SW0), .SW1(SW1), .SW2(SW2),
      .BTNC_DB(BTNC_DB), .SW0_DB(SW0_DB), .SW1_DB(SW1_DB), .SW2_DB(SW2_DB),
      .BTNC_RISE(BTNC_RISE), .BTNC_FALL(BTNC_FALL)
   );

   always #5 CLK = ~CLK;

   // in  = {BTNC, SW0, SW1, SW2}
   // exp = {BTNC_DB, SW0_DB, SW1_DB, SW2_DB, BTNC_RISE, BTNC_FALL} after that cycle's edge
   typedef struct {
      string      tag;
      logic [3:0] in;
      logic [5:0] exp;
   } vec_t;

   vec_t       vecs[$];
   logic [5:0] exp_q[$];
   int         errors = 0;
   int         checks = 0;

   function automatic logic [5:0] outs();
      return {BTNC_DB, SW0_DB, SW1_DB, SW2_DB, BTNC_RISE, BTNC_FALL};
   endfunction

   task automatic add(input string tag, input logic [3:0] in, input logic [5:0] exp, input int n);
      vec_t v;
      v.tag = tag; v.in = in; v.exp = exp;
      for (int k = 0; k < n; k++) vecs.push_back(v);
   endtask

   task automatic check(input string tag, input int idx, input logic [5:0] got, input logic [5:0] want);
      checks++;
      if (got !== want) begin
         errors++;
         $display("FAIL %s[%0d]: got %b want %b", tag, idx, got, want);
      end
   endtask

   // Drive each record just after an edge, queue its expectation, compare after the next edge.
   task automatic run_table();
      logic [5:0] want;
      for (int i = 0; i < vecs.size(); i++) begin
         {BTNC, SW0, SW1, SW2} = vecs[i].in;
         exp_q.push_back(vecs[i].exp);
         @(posedge CLK);
         #1;
         want = exp_q.pop_front();
         check(vecs[i].tag, i, outs(), want);
      end
      vecs.delete();
   endtask

   initial begin
      logic [7:0] bp;
      bp = 8'b1110_1110;

      repeat (3) @(posedge CLK);
      #1;
      check("reset_state", 0, outs(), 6'b000000);
      RST_N = 1'b1;

      add("press",   4'b1000, 6'b000000, 5);
      add("press",   4'b1000, 6'b100010, 1);
      add("press",   4'b1000, 6'b100000, 2);

      add("release", 4'b0000, 6'b100000, 5);
      add("release", 4'b0000, 6'b000001, 1);
      add("release", 4'b0000, 6'b000000, 2);

      for (int i = 0; i < 8; i++)
         add("bounce", bp[7-i] ? 4'b1000 : 4'b0000, 6'b000000, 1);
      add("bounce_hold", 4'b1000, 6'b000000, 5);
      add("bounce_hold", 4'b1000, 6'b100010, 1);
      add("bounce_hold", 4'b1000, 6'b100000, 1);

      add("release2", 4'b0000, 6'b100000, 5);
      add("release2", 4'b0000, 6'b000001, 1);
      add("release2", 4'b0000, 6'b000000, 2);

      for (int i = 0; i < 8; i++)
         add("multi", {2'b01, (i % 2 == 0), 1'b1}, (i < 5) ? 6'b000000 : 6'b010100, 1);
      add("multi_idle", 4'b0101, 6'b010100, 2);

      add("glitch3", 4'b0111, 6'b010100, 3);
      add("glitch3", 4'b0101, 6'b010100, 5);

      add("pulse4", 4'b0111, 6'b010100, 4);
      add("pulse4", 4'b0101, 6'b010100, 1);
      add("pulse4", 4'b0101, 6'b011100, 4);
      add("pulse4", 4'b0101, 6'b010100, 2);

      add("all_ones", 4'b1111, 6'b010100, 5);
      add("all_ones", 4'b1111, 6'b111110, 1);
      add("all_ones", 4'b1111, 6'b111100, 2);

      run_table();

      // Reset asserted between edges must clear every output without a clock edge.
      #2;
      RST_N = 1'b0;
      #1;
      check("async_reset", 0, outs(), 6'b000000);
      repeat (2) @(posedge CLK);
      #1;
      check("reset_held", 0, outs(), 6'b000000);
      RST_N = 1'b1;

      add("post_reset", 4'b1111, 6'b000000, 5);
      add("post_reset", 4'b1111, 6'b111110, 1);
      add("post_reset", 4'b1111, 6'b111100, 2);
      run_table();

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end
endmodule
